vid_timing_reader: RTL

VID_TIMING_READER -- requirements
Module: vid_timing_reader

---
 rtl/vid_pkg.sv | 42 ++++
 rtl/vid_tcnt.sv | 72 +++++++
 rtl/vid_timing_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vid_pkg.sv
// Shared video timing constants and colour-bar table.
// 720p30 defaults plus the stage-1 pipeline bundle.
package vid_pkg;

  localparam int H_ACTIVE_720 = 1280;
  localparam int H_FP_720     = 1760;
  localparam int H_SYNC_720   = 40;
  localparam int H_BP_720     = 220;
  localparam int V_ACTIVE_720 = 720;
  localparam int V_FP_720     = 5;
  localparam int V_SYNC_720   = 5;
  localparam int V_BP_720     = 20;

  localparam int BAR_W = 160;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       mode;
    logic [2:0] bar;
  } pix_s1_t;

  function automatic logic [23:0] bar_rgb(
    input logic [2:0] idx
  );
    logic [23:0] c;
    c = 24'h000000;
    unique case (idx)
      3'd0: c = 24'hFFFFFF;
      3'd1: c = 24'hFFFF00;
      3'd2: c = 24'h00FFFF;
      3'd3: c = 24'h00FF00;
      3'd4: c = 24'hFF00FF;
      3'd5: c = 24'hFF0000;
      3'd6: c = 24'h0000FF;
      3'd7: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vid_tcnt.sv
// Horizontal/vertical pixel counters and sync decode.
// All outputs are stage 0 (same cycle as the counters).
module vid_tcnt
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720,
  parameter int H_FP     = H_FP_720,
  parameter int H_SYNC   = H_SYNC_720,
  parameter int H_BP     = H_BP_720,
  parameter int V_ACTIVE = V_ACTIVE_720,
  parameter int V_FP     = V_FP_720,
  parameter int V_SYNC   = V_SYNC_720,
  parameter int V_BP     = V_BP_720,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int HW       = 12,
  parameter int VW       = 10
) (
  input  logic          pclk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          act,
  output logic          v_act,
  output logic          hs,
  output logic          vs,
  output logic          frame_wrap
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;
  logic v_wrap;
  logic hs_on;
  logic vs_on;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Raster scan: h wraps each line, v advances on the h wrap.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  assign hs_on = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_on = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

  assign hs         = hs_on ? HS_POL : ~HS_POL;
  assign vs         = vs_on ? VS_POL : ~VS_POL;
  assign v_act      = (v_cnt < V_ACT);
  assign act        = (h_cnt < H_ACT) && v_act;
  assign frame_wrap = h_wrap && v_wrap;

endmodule

// File: rtl/vid_timing_reader.sv
// Video timing generator reading pixels from a frame-buffer FIFO.
// Stage 0 counters, stage 1 FIFO pop, stage 2 video out.
module vid_timing_reader
  import vid_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_720,
  parameter int H_FP      = H_FP_720,
  parameter int H_SYNC    = H_SYNC_720,
  parameter int H_BP      = H_BP_720,
  parameter int V_ACTIVE  = V_ACTIVE_720,
  parameter int V_FP      = V_FP_720,
  parameter int V_SYNC    = V_SYNC_720,
  parameter int V_BP      = V_BP_720,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int C_R_WIDTH = 32
) (
  input  logic                 rframe_pclk,
  input  logic                 rframe_reset_n,
  input  logic                 pattern_sel,
  output logic                 rframe_vsync,
  output logic                 rframe_data_en,
  input  logic [C_R_WIDTH-1:0] rframe_data,
  output logic                 vid_hs,
  output logic                 vid_vs,
  output logic                 vid_de,
  output logic [23:0]          vid_rgb,
  output logic [15:0]          frame_cnt
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          act;
  logic          v_act;
  logic          hs0;
  logic          vs0;
  logic          frame_wrap;
  logic          mode_q;
  logic          mode_s0;
  logic [HW-1:0] bdiv;
  logic [2:0]    bar_s0;
  pix_s1_t       s1;
  logic          mode_s2;
  logic [23:0]   bar_q;

  if (C_R_WIDTH > 24) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^rframe_data[C_R_WIDTH-1:24];
  end

  // Asynchronous assert, two-flop synchronous release.
  always_ff @(posedge rframe_pclk or negedge rframe_reset_n) begin
    if (!rframe_reset_n) rst_sync_q <= 2'b00;
    else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  vid_tcnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL),
    .HW       (HW),
    .VW       (VW)
  ) u_tcnt (
    .pclk       (rframe_pclk),
    .rst_n      (rst_n),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .act        (act),
    .v_act      (v_act),
    .hs         (hs0),
    .vs         (vs0),
    .frame_wrap (frame_wrap)
  );

  // The first pixel of a frame already obeys a newly sampled mode.
  assign mode_s0 = ((h_cnt == '0) && (v_cnt == '0)) ?
                   pattern_sel : mode_q;

  assign bdiv   = h_cnt / HW'(BAR_W);
  assign bar_s0 = (bdiv > HW'(7)) ? 3'd7 : bdiv[2:0];

  // Stage 1: latch mode, issue FIFO pop, carry timing forward.
  always_ff @(posedge rframe_pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q         <= 1'b0;
      rframe_data_en <= 1'b0;
      rframe_vsync   <= 1'b0;
      s1 <= '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL,
              mode: 1'b0, bar: 3'd0};
    end else begin
      mode_q         <= mode_s0;
      rframe_data_en <= act & ~mode_s0;
      rframe_vsync   <= v_act;
      s1 <= '{de: act, hs: hs0, vs: vs0,
              mode: mode_s0, bar: bar_s0};
    end
  end

  // Stage 2: timing outputs line up with the FIFO read data.
  always_ff @(posedge rframe_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vid_de  <= 1'b0;
      vid_hs  <= ~HS_POL;
      vid_vs  <= ~VS_POL;
      mode_s2 <= 1'b0;
      bar_q   <= 24'h000000;
    end else begin
      vid_de  <= s1.de;
      vid_hs  <= s1.hs;
      vid_vs  <= s1.vs;
      mode_s2 <= s1.mode;
      bar_q   <= bar_rgb(s1.bar);
    end
  end

  // Completed-frame counter, bumped on the last pixel of a frame.
  always_ff @(posedge rframe_pclk or negedge rst_n) begin
    if (!rst_n)          frame_cnt <= 16'd0;
    else if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
  end

  // Pixel mux: FIFO data arrives combinationally the cycle after the pop.
  always_comb begin
    vid_rgb = 24'h000000;
    if (vid_de) vid_rgb = mode_s2 ? bar_q : rframe_data[23:0];
  end

endmodule
